// File: rtl/data_mem_bridge.sv
// Data-side bridge for the single-cycle core: word-organised RAM plus a small
// MMIO block (LED, synchronised switches, timer/compare, sticky status).
module data_mem_bridge #(
  parameter int unsigned DM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h0000_7F00,
  parameter int unsigned SW_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Mem_Write,
  input  logic [31:0]     Address,
  input  logic [31:0]     Data_Write,
  input  logic [1:0]      Memory_Byte,
  output logic [31:0]     Data_Read,
  input  logic [SW_W-1:0] sw_in,
  output logic [SW_W-1:0] led_out,
  output logic            timer_irq,
  output logic            align_err
);

  localparam int unsigned AW = $clog2(DM_WORDS);

  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_SW     = 3'd1;
  localparam logic [2:0] OFF_TCNT   = 3'd2;
  localparam logic [2:0] OFF_TCMP   = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  logic [31:0]     mem_q [DM_WORDS];

  logic [SW_W-1:0] led_q, led_d;
  logic [SW_W-1:0] sw_meta_q, sw_meta_d;
  logic [SW_W-1:0] sw_sync_q, sw_sync_d;
  logic [31:0]     tcnt_q, tcnt_d;
  logic [31:0]     tcmp_q, tcmp_d;
  logic [1:0]      status_q, status_d;

  logic            ram_hit, mmio_hit;
  logic            is_word, is_half, is_byte;
  logic            misaligned, store_ok, ram_we, mmio_we;
  logic [AW-1:0]   idx;
  logic [2:0]      off;
  logic [3:0]      be;
  logic [31:0]     wdata;

  assign ram_hit    = (Address[31:AW+2] == '0);
  assign mmio_hit   = (Address[31:5] == MMIO_BASE[31:5]);
  assign idx        = Address[AW+1:2];
  assign off        = Address[4:2];

  assign is_half    = (Memory_Byte == 2'b01);
  assign is_byte    = (Memory_Byte == 2'b10);
  assign is_word    = !is_half && !is_byte;

  assign misaligned = (is_word && (Address[1:0] != 2'b00)) || (is_half && Address[0]);
  assign store_ok   = Mem_Write && !misaligned;
  assign ram_we     = store_ok && ram_hit;
  // MMIO registers only accept full-word stores.
  assign mmio_we    = store_ok && !ram_hit && mmio_hit && is_word;

  assign align_err  = rst && Mem_Write && misaligned;
  assign led_out    = led_q;
  assign timer_irq  = status_q[0];

  always_comb begin
    be    = 4'b0000;
    wdata = Data_Write;
    if (is_half) begin
      be    = Address[1] ? 4'b1100 : 4'b0011;
      wdata = {2{Data_Write[15:0]}};
    end else if (is_byte) begin
      be    = 4'b0001 << Address[1:0];
      wdata = {4{Data_Write[7:0]}};
    end else begin
      be    = 4'b1111;
    end
  end

  // RAM is not reset; stores during reset still land here.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    led_d     = led_q;
    tcnt_d    = tcnt_q + 32'd1;
    tcmp_d    = tcmp_q;
    status_d  = status_q;
    sw_meta_d = sw_in;
    sw_sync_d = sw_meta_q;
    if (mmio_we) begin
      case (off)
        OFF_LED:    led_d    = Data_Write[SW_W-1:0];
        OFF_TCNT:   tcnt_d   = Data_Write;
        OFF_TCMP:   tcmp_d   = Data_Write;
        OFF_STATUS: status_d = status_q & ~Data_Write[1:0];
        default:    ;
      endcase
    end
    // Sets are applied after W1C so a coincident set wins.
    if (tcnt_q == tcmp_q)         status_d[0] = 1'b1;
    if (Mem_Write && misaligned)  status_d[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      tcnt_q    <= 32'd0;
      tcmp_q    <= 32'hFFFF_FFFF;
      status_q  <= 2'b00;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      tcnt_q    <= tcnt_d;
      tcmp_q    <= tcmp_d;
      status_q  <= status_d;
    end
  end

  always_comb begin
    Data_Read = 32'd0;
    if (ram_hit) begin
      Data_Read = mem_q[idx];
    end else if (mmio_hit) begin
      case (off)
        OFF_LED:    Data_Read = 32'(led_q);
        OFF_SW:     Data_Read = 32'(sw_sync_q);
        OFF_TCNT:   Data_Read = tcnt_q;
        OFF_TCMP:   Data_Read = tcmp_q;
        OFF_STATUS: Data_Read = {30'd0, status_q};
        default:    Data_Read = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge: RAM lanes, alignment, MMIO, timer, reset.
module tb_data_mem_bridge;

  localparam logic [31:0] MB = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        rst;
  logic        Mem_Write;
  logic [31:0] Address;
  logic [31:0] Data_Write;
  logic [1:0]  Memory_Byte;
  logic [31:0] Data_Read;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        timer_irq;
  logic        align_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .Mem_Write   (Mem_Write),
    .Address     (Address),
    .Data_Write  (Data_Write),
    .Memory_Byte (Memory_Byte),
    .Data_Read   (Data_Read),
    .sw_in       (sw_in),
    .led_out     (led_out),
    .timer_irq   (timer_irq),
    .align_err   (align_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    Mem_Write   = 1'b1;
    Address     = a;
    Data_Write  = d;
    Memory_Byte = sz;
    tick();
    Mem_Write   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    Mem_Write = 1'b0;
    Address   = a;
    #1;
    chk(tag, Data_Read, exp);
  endtask

  initial begin
    rst = 1'b0; Mem_Write = 1'b0; Address = 32'd0; Data_Write = 32'd0;
    Memory_Byte = 2'b00; sw_in = 16'd0;
    tick(); tick();
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_irq", 32'(timer_irq), 32'd0);
    chk("rst_align", 32'(align_err), 32'd0);
    rd(MB + 32'h0C, 32'hFFFF_FFFF, "rst_tcmp");
    rd(MB + 32'h08, 32'h0000_0000, "rst_tcnt");
    rst = 1'b1;

    // word and byte stores
    store(32'h10, 32'h1122_3344, 2'b00);
    rd(32'h10, 32'h1122_3344, "word_store");
    Mem_Write = 1'b1; Address = 32'h12; Data_Write = 32'h0000_00AB; Memory_Byte = 2'b10;
    #1 chk("rd_during_wr_old", Data_Read, 32'h1122_3344);
    tick(); Mem_Write = 1'b0;
    rd(32'h10, 32'h11AB_3344, "byte_store");

    // halfword stores and misalignment
    store(32'h20, 32'h0000_0000, 2'b00);
    store(32'h22, 32'h0000_BEEF, 2'b01);
    rd(32'h20, 32'hBEEF_0000, "half_hi");
    Mem_Write = 1'b1; Address = 32'h21; Data_Write = 32'h0000_1234; Memory_Byte = 2'b01;
    #1 chk("align_pulse", 32'(align_err), 32'd1);
    tick(); Mem_Write = 1'b0;
    #1 chk("align_drop", 32'(align_err), 32'd0);
    rd(32'h20, 32'hBEEF_0000, "misalign_nowrite");
    rd(MB + 32'h10, 32'h0000_0002, "status_misalign");
    store(MB + 32'h10, 32'h0000_0002, 2'b00);
    rd(MB + 32'h10, 32'h0000_0000, "status_w1c_bit1");
    store(32'h20, 32'h0000_CAFE, 2'b01);
    rd(32'h20, 32'hBEEF_CAFE, "half_lo");
    store(32'h2000, 32'h1234_5678, 2'b00);
    rd(32'h2000, 32'h0000_0000, "unmapped_read");
    rd(MB + 32'h14, 32'h0000_0000, "mmio_hole");

    // LED register
    store(MB, 32'h0000_5A5A, 2'b00);
    chk("led_word", 32'(led_out), 32'h0000_5A5A);
    store(MB, 32'h0000_00FF, 2'b10);
    chk("led_byte_ignored", 32'(led_out), 32'h0000_5A5A);
    rd(MB, 32'h0000_5A5A, "led_read");

    // switch synchroniser
    sw_in = 16'h00F0;
    rd(MB + 32'h04, 32'h0000_0000, "sw_same_cycle");
    tick();
    rd(MB + 32'h04, 32'h0000_0000, "sw_n_plus_1");
    tick();
    rd(MB + 32'h04, 32'h0000_00F0, "sw_n_plus_2");

    // timer compare
    store(MB + 32'h0C, 32'd5, 2'b00);
    store(MB + 32'h08, 32'd0, 2'b00);
    rd(MB + 32'h08, 32'd0, "tcnt_loaded");
    for (int i = 0; i < 5; i++) tick();
    rd(MB + 32'h08, 32'd5, "tcnt_5");
    chk("irq_before_match", 32'(timer_irq), 32'd0);
    tick();
    chk("irq_on_match", 32'(timer_irq), 32'd1);
    rd(MB + 32'h08, 32'd6, "tcnt_6");
    tick(); tick(); tick();
    chk("irq_sticky", 32'(timer_irq), 32'd1);
    store(MB + 32'h10, 32'h0000_0001, 2'b00);
    chk("irq_w1c", 32'(timer_irq), 32'd0);
    store(MB + 32'h0C, 32'd100, 2'b00);
    store(MB + 32'h08, 32'd100, 2'b00);
    chk("irq_pre_race", 32'(timer_irq), 32'd0);
    store(MB + 32'h10, 32'h0000_0001, 2'b00);
    chk("irq_set_wins", 32'(timer_irq), 32'd1);

    // wrap and reset
    store(MB + 32'h08, 32'hFFFF_FFFF, 2'b00);
    rd(MB + 32'h08, 32'hFFFF_FFFF, "tcnt_max");
    tick();
    rd(MB + 32'h08, 32'h0000_0000, "tcnt_wrap");
    rst = 1'b0; Mem_Write = 1'b1; Address = MB; Data_Write = 32'h0000_1234; Memory_Byte = 2'b00;
    tick();
    chk("rst_led_discard", 32'(led_out), 32'd0);
    chk("rst_irq_clear", 32'(timer_irq), 32'd0);
    Address = 32'h30; Data_Write = 32'hDEAD_BEEF;
    tick();
    rst = 1'b1; Mem_Write = 1'b0;
    #1 chk("post_rst_align", 32'(align_err), 32'd0);
    rd(MB + 32'h08, 32'h0000_0000, "post_rst_tcnt");
    rd(MB + 32'h10, 32'h0000_0000, "post_rst_status");
    rd(32'h30, 32'hDEAD_BEEF, "ram_store_in_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
